distram_var_delay: RTL and testbench
====================================

DISTRAM_VAR_DELAY -- requirements
Module: distram_var_delay

Interface
REQ-001 SHALL have parameter NSAMP, default 1, number of independent sample lanes sharing one address pair.
REQ-002 SHALL have parameter NBITS, default 14, bits per sample.
REQ-003 SHALL have parameter ADDRBITS, default 5, RAM address width; DEPTH = 2**ADDRBITS (32 or 64 legal).
REQ-004 SHALL have parameter DEFAULT_DELAY, default 6, total latency in clocks loaded at reset.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rstn_i  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port dat_i  input  NBITS*NSAMP  samples written every clock.
REQ-008 SHALL have port dat_o  output  NBITS*NSAMP  registered delayed samples.
REQ-009 SHALL have port dat_valid_o  output  1  high when dat_o carries a sample delayed by the current delay.
REQ-010 SHALL have port delay_i  input  ADDRBITS+1  requested total latency in clocks.
REQ-011 SHALL have port delay_wr_i  input  1  one-cycle strobe loading delay_i.
REQ-012 SHALL have port delay_o  output  ADDRBITS+1  currently applied (clamped) delay.

Function
REQ-013 SHALL write dat_i into RAM at wraddr every clock, unconditionally; dat_i is not handshaked.
REQ-014 SHALL read RAM asynchronously at rdaddr and register the result into dat_o; no other pipeline stage.
REQ-015 SHALL keep wraddr - rdaddr == D-1 modulo DEPTH, giving dat_i at cycle t on dat_o at cycle t+D, where D = delay_o.
REQ-016 SHALL increment wraddr and rdaddr by 1 every clock, wrapping DEPTH-1 -> 0 with no discontinuity in output.
REQ-017 SHALL clamp any loaded delay to [2, DEPTH]: values below 2 give 2, values above DEPTH give DEPTH.
REQ-018 SHALL use two states: FILL (history invalid) and RUN (dat_o valid).
REQ-019 SHALL on delay_wr_i high, in either state: set delay_o to clamped delay_i, set rdaddr to 0 and wraddr to D-1 on the next edge, clear fill counter, enter FILL.
REQ-020 SHALL in FILL count clocks from the load/reset edge; when the count reaches D, i.e. D cycles after the restart, set dat_valid_o high and enter RUN.
REQ-021 SHALL drive dat_o to all-zero whenever dat_valid_o is low; stale RAM contents never appear.
REQ-022 SHALL accept back-to-back delay_wr_i strobes; each restarts FILL with the newest value.
REQ-023 SHALL treat DEPTH as legal: wraddr == rdaddr - 1 modulo DEPTH, the read occurring before that address is overwritten.

Reset
REQ-024 SHALL on rstn_i low at a rising edge: delay_o = clamped DEFAULT_DELAY, rdaddr = 0, wraddr = delay_o-1, fill count 0, state FILL, dat_o = 0, dat_valid_o = 0.
REQ-025 SHALL give reset priority over a coincident delay_wr_i; the strobe is discarded.
REQ-026 SHALL not reset RAM contents; REQ-021 masks them.

Structure
REQ-027 SHALL place the state enum, MIN_DELAY = 2 constant, and the clamp function in shared package distram_delay_pkg.
REQ-028 SHALL instantiate one sub-module per lane, distram_sdp_ram, NBITS wide, DEPTH deep, async read, one write port.

Verification
REQ-029 SHALL cover reset with DEFAULT_DELAY=6, ramp dat_i=cycle index -> dat_valid_o rises at cycle 6, dat_o=0 at that cycle, then dat_o = index-6.
REQ-030 SHALL cover delay_wr_i with delay_i=20 during RUN -> dat_valid_o low for 20 cycles, dat_o=0, then dat_o = index-20.
REQ-031 SHALL cover delay_i=0 and then delay_i=63 with ADDRBITS=5 -> delay_o=2, then delay_o=32; latencies 2 and 32 measured.
REQ-032 SHALL cover 200 cycles with D=32, ADDRBITS=5 -> no glitch across address wrap, dat_o = index-32 throughout.
REQ-033 SHALL cover rstn_i low coincident with delay_wr_i, delay_i=10 -> delay_o = DEFAULT_DELAY, strobe ignored.
REQ-034 SHALL cover NSAMP=4 with distinct per-lane ramps -> each lane delayed identically, no lane crosstalk.

Source files
------------

// File: rtl/distram_delay_pkg.sv
// rtl/distram_delay_pkg.sv - shared state enum, minimum delay and delay clamp
package distram_delay_pkg;

  // FILL: history not yet valid for the current delay; RUN: dat_o valid
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A delay of 1 would need read-during-write of the same address
  localparam int MIN_DELAY = 2;

  function automatic int clamp_delay(input int req, input int depth);
    if (req < MIN_DELAY) return MIN_DELAY;
    if (req > depth)     return depth;
    return req;
  endfunction

endpackage

// File: rtl/distram_sdp_ram.sv
// rtl/distram_sdp_ram.sv - simple dual-port distributed RAM, sync write, async read
// Ports:
//   i_clk     : write clock
//   i_we      : write enable
//   i_wraddr  : write address
//   i_wdata   : write data
//   i_rdaddr  : asynchronous read address
//   o_rdata   : read data (combinational from i_rdaddr)
module distram_sdp_ram #(
  parameter int WIDTH    = 14,
  parameter int ADDRBITS = 5
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [ADDRBITS-1:0] i_wraddr,
  input  logic [WIDTH-1:0]    i_wdata,
  input  logic [ADDRBITS-1:0] i_rdaddr,
  output logic [WIDTH-1:0]    o_rdata
);

  localparam int DEPTH = 2 ** ADDRBITS;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wraddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_rdaddr];

endmodule

// File: rtl/distram_var_delay.sv
// rtl/distram_var_delay.sv - variable-latency sample delay line on distributed RAM
// Ports:
//   clk_i        : clock, rising edge
//   rstn_i       : synchronous active-low reset
//   dat_i        : NSAMP lanes of NBITS samples, written every clock
//   dat_o        : registered delayed samples, zero while not valid
//   dat_valid_o  : dat_o carries samples delayed by delay_o
//   delay_i      : requested total latency in clocks
//   delay_wr_i   : one-cycle strobe loading delay_i
//   delay_o      : applied latency after clamping to [2, DEPTH]
module distram_var_delay
  import distram_delay_pkg::*;
#(
  parameter int NSAMP         = 1,
  parameter int NBITS         = 14,
  parameter int ADDRBITS      = 5,
  parameter int DEFAULT_DELAY = 6
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NBITS*NSAMP-1:0]    dat_i,
  output logic [NBITS*NSAMP-1:0]    dat_o,
  output logic                      dat_valid_o,
  input  logic [ADDRBITS:0]         delay_i,
  input  logic                      delay_wr_i,
  output logic [ADDRBITS:0]         delay_o
);

  localparam int DEPTH = 2 ** ADDRBITS;
  localparam int DW    = ADDRBITS + 1;
  localparam int NW    = NBITS * NSAMP;

  localparam logic [DW-1:0]       ONE       = DW'(1);
  localparam logic [ADDRBITS-1:0] A_ONE     = ADDRBITS'(1);
  localparam logic [DW-1:0]       RST_DELAY = DW'(clamp_delay(DEFAULT_DELAY, DEPTH));
  // Low ADDRBITS of DEPTH are zero, so "D-1" wraps to DEPTH-1 as required
  localparam logic [ADDRBITS-1:0] RST_WA    = RST_DELAY[ADDRBITS-1:0] - A_ONE;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_valid_nxt;
  logic [DW-1:0]       r_delay;
  logic [DW-1:0]       r_cnt;
  logic [ADDRBITS-1:0] r_rdaddr;
  logic [ADDRBITS-1:0] r_wraddr;
  logic [NW-1:0]       r_dat;
  logic                r_valid;
  logic [NW-1:0]       w_rd_dat;
  logic [DW-1:0]       w_delay_ld;
  logic [ADDRBITS-1:0] w_wa_ld;

  assign w_delay_ld = DW'(clamp_delay(int'(delay_i), DEPTH));
  assign w_wa_ld    = w_delay_ld[ADDRBITS-1:0] - A_ONE;

  for (genvar l = 0; l < NSAMP; l++) begin : g_lane
    distram_sdp_ram #(
      .WIDTH    (NBITS),
      .ADDRBITS (ADDRBITS)
    ) u_ram (
      .i_clk    (clk_i),
      .i_we     (1'b1),
      .i_wraddr (r_wraddr),
      .i_wdata  (dat_i[l*NBITS +: NBITS]),
      .i_rdaddr (r_rdaddr),
      .o_rdata  (w_rd_dat[l*NBITS +: NBITS])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fill completes on the edge that is D clocks after the restart edge:
  // the read address then points at the first sample written after restart.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    if (delay_wr_i) begin
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: if (r_cnt == r_delay - ONE) w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_FILL;
      endcase
    end
    w_valid_nxt = (w_state_nxt == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_delay  <= RST_DELAY;
      r_rdaddr <= '0;
      r_wraddr <= RST_WA;
      r_cnt    <= '0;
      r_dat    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_valid_nxt;
      r_dat   <= w_valid_nxt ? w_rd_dat : '0;
      if (delay_wr_i) begin
        r_delay  <= w_delay_ld;
        r_rdaddr <= '0;
        r_wraddr <= w_wa_ld;
        r_cnt    <= '0;
      end else begin
        r_rdaddr <= r_rdaddr + A_ONE;
        r_wraddr <= r_wraddr + A_ONE;
        if (r_state == ST_FILL) begin
          r_cnt <= r_cnt + ONE;
        end
      end
    end
  end

  assign dat_o       = r_dat;
  assign dat_valid_o = r_valid;
  assign delay_o     = r_delay;

endmodule

// File: tb/tb_distram_var_delay.sv
// tb/tb_distram_var_delay.sv - self-checking bench for distram_var_delay
module tb_distram_var_delay;

  localparam int NSAMP    = 4;
  localparam int NBITS    = 14;
  localparam int ADDRBITS = 5;
  localparam int DEF_DLY  = 6;
  localparam int DEPTH    = 32;
  localparam int NW       = NSAMP * NBITS;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic [NW-1:0]     dat_i;
  logic [NW-1:0]     dat_o;
  logic              dat_valid_o;
  logic [ADDRBITS:0] delay_i;
  logic              delay_wr_i;
  logic [ADDRBITS:0] delay_o;

  distram_var_delay #(
    .NSAMP         (NSAMP),
    .NBITS         (NBITS),
    .ADDRBITS      (ADDRBITS),
    .DEFAULT_DELAY (DEF_DLY)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .dat_valid_o (dat_valid_o),
    .delay_i     (delay_i),
    .delay_wr_i  (delay_wr_i),
    .delay_o     (delay_o)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  logic [NW-1:0] q[$];
  int   m_delay;
  int   m_cnt;
  logic m_valid;
  int   cyc;
  int   since_ld;
  int   lat_meas;
  logic prev_valid;

  function automatic int tb_clamp(input int d);
    if (d < 2)     return 2;
    if (d > DEPTH) return DEPTH;
    return d;
  endfunction

  // Lane l carries {l, cycle[11:0]} so any crosstalk shows up in the top bits
  function automatic logic [NW-1:0] samp(input int n);
    logic [NW-1:0] s;
    s = '0;
    for (int l = 0; l < NSAMP; l++) begin
      s[l*NBITS +: NBITS] = 14'((l << 12) | (n & 12'hfff));
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: compare the current interval's outputs, drive next inputs,
  // advance the reference model for the coming edge.
  task automatic step(input logic rst, input logic wr, input int dly);
    logic [NW-1:0] exp_d;
    @(posedge clk);
    #1;
    check("valid", 64'(dat_valid_o), 64'(m_valid));
    check("delay_o", 64'(delay_o), 64'(m_delay));
    if (m_valid) begin
      if (q.size() == 0) begin
        check("queue_empty", 64'(q.size()), 64'(1));
      end else begin
        exp_d = q.pop_front();
        check("dat_o", 64'(dat_o), 64'(exp_d));
      end
    end else begin
      check("dat_o_zero", 64'(dat_o), 64'(0));
    end
    if (dat_valid_o === 1'b1 && prev_valid !== 1'b1) lat_meas = since_ld;
    prev_valid = dat_valid_o;

    dat_i      = samp(cyc);
    rstn_i     = ~rst;
    delay_wr_i = wr;
    delay_i    = (ADDRBITS+1)'(dly);

    if (rst || wr) begin
      m_delay  = rst ? tb_clamp(DEF_DLY) : tb_clamp(dly);
      q.delete();
      m_cnt    = 0;
      m_valid  = 1'b0;
      since_ld = 0;
      lat_meas = -1;
    end else begin
      q.push_back(samp(cyc));
      since_ld++;
      if (!m_valid) begin
        m_cnt++;
        if (m_cnt == m_delay) m_valid = 1'b1;
      end
    end
    cyc++;
  endtask

  initial begin
    rstn_i     = 1'b0;
    delay_wr_i = 1'b0;
    delay_i    = '0;
    dat_i      = '0;
    cyc        = 0;
    prev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_delay  = DEF_DLY;
    m_cnt    = 0;
    m_valid  = 1'b0;
    since_ld = 0;
    lat_meas = -1;

    // Reset state, then default delay of 6 from a ramp
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 0);
    check("lat_default", 64'(lat_meas), 64'(6));

    // Reload to 20 while running
    step(1'b0, 1'b1, 20);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 0);
    check("lat_20", 64'(lat_meas), 64'(20));

    // Clamp low: 0 -> 2
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0);
    check("clamp_lo", 64'(delay_o), 64'(2));
    check("lat_2", 64'(lat_meas), 64'(2));

    // Clamp high: 63 -> 32, long run across many address wraps
    step(1'b0, 1'b1, 63);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 0);
    check("clamp_hi", 64'(delay_o), 64'(32));
    check("lat_32", 64'(lat_meas), 64'(32));

    // Reset coincident with a strobe: strobe discarded
    step(1'b1, 1'b1, 10);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 0);
    check("rst_prio", 64'(delay_o), 64'(DEF_DLY));
    check("lat_rst", 64'(lat_meas), 64'(6));

    // Back-to-back strobes: newest wins
    step(1'b0, 1'b1, 10);
    step(1'b0, 1'b1, 3);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0);
    check("b2b_delay", 64'(delay_o), 64'(3));
    check("lat_b2b", 64'(lat_meas), 64'(3));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
